// File: rtl/systolic_seq_ctrl_if.sv
// Instruction handshake and datapath control bundle for the systolic sequencer.
// master = sequencer side, slave = instruction queue / datapath side.
interface systolic_seq_ctrl_if #(
    parameter int TILE_W = 8
);
    logic              inst_valid;
    logic [TILE_W-1:0] inst_ntiles;
    logic              inst_ready;
    logic              abort;
    logic              w_done;
    logic              if_done;
    logic              rd_nxt_inst;
    logic              w_buffer_read;
    logic              if_buffer_read;
    logic              clr_w;
    logic              clr_if;
    logic              switch;
    logic              first;
    logic              last;
    logic              busy;
    logic [TILE_W-1:0] tile_idx;
    logic              done;
    logic              err;

    modport master (
        input  inst_valid, inst_ntiles, abort, w_done, if_done, rd_nxt_inst,
        output inst_ready, w_buffer_read, if_buffer_read, clr_w, clr_if,
               switch, first, last, busy, tile_idx, done, err
    );

    modport slave (
        output inst_valid, inst_ntiles, abort, w_done, if_done, rd_nxt_inst,
        input  inst_ready, w_buffer_read, if_buffer_read, clr_w, clr_if,
               switch, first, last, busy, tile_idx, done, err
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// GEMM tile sequencer: per tile LOAD_W -> SWITCH -> STREAM, then DRAIN; done/err are registered pulses.
// Accepts an instruction only in IDLE; datapath pacing comes from w_done/if_done/rd_nxt_inst.
module systolic_seq_ctrl #(
    parameter int TILE_W  = 8,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic                clk,
    input  logic                rst,
    systolic_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SWITCH,
        STREAM,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [TILE_W-1:0] ntiles_q, ntiles_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic final_tile;
    logic waiting;
    logic wd_expired;

    assign final_tile = (tile_idx_q == ntiles_q - TILE_W'(1));
    assign waiting    = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
    assign wd_expired = waiting && (wd_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ntiles_q   <= '0;
            tile_idx_q <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ntiles_q   <= ntiles_d;
            tile_idx_q <= tile_idx_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ntiles_d   = ntiles_q;
        tile_idx_d = tile_idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wd_d       = '0;

        case (state_q)
            IDLE: begin
                if (bus.inst_valid) begin
                    ntiles_d   = bus.inst_ntiles;
                    tile_idx_d = '0;
                    if (bus.inst_ntiles == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (bus.w_done) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (bus.if_done) begin
                    if (final_tile) begin
                        state_d = DRAIN;
                    end else begin
                        tile_idx_d = tile_idx_q + TILE_W'(1);
                        state_d    = LOAD_W;
                    end
                end
            end
            DRAIN: begin
                if (bus.rd_nxt_inst) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A legitimate transition on the expiry cycle wins over the watchdog.
        if (wd_expired && (state_d == state_q)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end

        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        if ((state_d == state_q) && waiting) begin
            wd_d = wd_q + TO_W'(1);
        end
    end

    assign bus.inst_ready     = (state_q == IDLE);
    assign bus.clr_w          = (state_q != LOAD_W);
    assign bus.clr_if         = (state_q != STREAM);
    assign bus.w_buffer_read  = (state_q == LOAD_W) && !bus.w_done;
    assign bus.if_buffer_read = (state_q == STREAM) && !bus.if_done;
    assign bus.switch         = (state_q == SWITCH);
    assign bus.first          = (state_q == STREAM) && (tile_idx_q == '0);
    assign bus.last           = (state_q == STREAM) && final_tile;
    assign bus.busy           = (state_q != IDLE);
    assign bus.tile_idx       = tile_idx_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
endmodule
